// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler: load-use and MDU stall/flush control with MDU timeout trap.
// Optional stall-cycle counter enabled by defining HAZ_STALL_CNT_EN.
module hazard_scheduler #(
  parameter int unsigned MDU_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadEX,
  input  logic [4:0]  writeregEX,
  input  logic [4:0]  insrs,
  input  logic [4:0]  insrt,
  input  logic        UseRsID,
  input  logic        UseRtID,
  input  logic        BranchTakenEX,
  input  logic        MduStartID,
  input  logic        MduUseID,
  input  logic        MduDone,
  output logic        PChold,
  output logic        IFIDhold,
  output logic        IDEXflush,
  output logic        IFIDflush,
  output logic        MduBusy,
  output logic        MduErr,
  output logic [15:0] StallCnt
);

  typedef enum logic [1:0] {RUN, MDU_WAIT, MDU_ERR} state_t;

  localparam logic [5:0] WCNT_LAST = 6'(MDU_TIMEOUT - 1);

  state_t     state;
  logic [5:0] wcnt;
  logic       lu;
  logic       mw;
  logic       start_ok;

  assign lu = MemReadEX && (writeregEX != 5'd0) &&
              ((UseRsID && (writeregEX == insrs)) || (UseRtID && (writeregEX == insrt)));
  assign mw = (state == MDU_WAIT) && MduUseID && !MduDone;

  // A start is only taken when the ID instruction actually leaves ID this cycle.
  assign start_ok = MduStartID && !BranchTakenEX && !lu && !mw && (state != MDU_ERR);

  assign MduBusy = (state == MDU_WAIT);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    PChold    = 1'b0;
    IFIDhold  = 1'b0;
    IDEXflush = 1'b0;
    IFIDflush = 1'b0;
    if (BranchTakenEX) begin
      IFIDflush = 1'b1;
      IDEXflush = 1'b1;
    end else if (lu || mw || (state == MDU_ERR)) begin
      PChold    = 1'b1;
      IFIDhold  = 1'b1;
      IDEXflush = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      wcnt   <= '0;
      MduErr <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (start_ok) begin
            state <= MDU_WAIT;
            wcnt  <= '0;
          end
        end
        MDU_WAIT: begin
          if (start_ok) begin
            wcnt <= '0;
          end else if (MduDone) begin
            state <= RUN;
            wcnt  <= '0;
          end else if (wcnt == WCNT_LAST) begin
            state  <= MDU_ERR;
            MduErr <= 1'b1;
          end else begin
            wcnt <= wcnt + 6'd1;
          end
        end
        MDU_ERR: begin
          // Trapped until reset; the hold outputs keep the front end frozen.
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZ_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCnt <= '0;
    end else if (PChold && (StallCnt != 16'hFFFF)) begin
      StallCnt <= StallCnt + 16'd1;
    end
  end
`else
  assign StallCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: directed vector table, hand-written
// corner sequences, and randomized stimulus against a behavioural model.
module tb_hazard_scheduler;

  localparam int TO = 8;
`ifdef HAZ_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef struct {
    logic       memread;
    logic [4:0] wreg;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       br;
    logic       start;
    logic       mdu_use;
    logic       done;
  } stim_t;

  // exp = {PChold, IFIDhold, IDEXflush, IFIDflush, MduBusy}
  typedef struct {
    stim_t      s;
    logic [4:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadEX;
  logic [4:0]  writeregEX;
  logic [4:0]  insrs;
  logic [4:0]  insrt;
  logic        UseRsID;
  logic        UseRtID;
  logic        BranchTakenEX;
  logic        MduStartID;
  logic        MduUseID;
  logic        MduDone;
  logic        PChold;
  logic        IFIDhold;
  logic        IDEXflush;
  logic        IFIDflush;
  logic        MduBusy;
  logic        MduErr;
  logic [15:0] StallCnt;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  bit m_busy;
  bit m_err;
  int m_waited;
  int m_stalls;

  hazard_scheduler #(.MDU_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemReadEX    (MemReadEX),
    .writeregEX   (writeregEX),
    .insrs        (insrs),
    .insrt        (insrt),
    .UseRsID      (UseRsID),
    .UseRtID      (UseRtID),
    .BranchTakenEX(BranchTakenEX),
    .MduStartID   (MduStartID),
    .MduUseID     (MduUseID),
    .MduDone      (MduDone),
    .PChold       (PChold),
    .IFIDhold     (IFIDhold),
    .IDEXflush    (IDEXflush),
    .IFIDflush    (IFIDflush),
    .MduBusy      (MduBusy),
    .MduErr       (MduErr),
    .StallCnt     (StallCnt)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic stim_t st(input logic memread, input logic [4:0] wreg, input logic [4:0] rs,
                               input logic [4:0] rt, input logic use_rs, input logic use_rt,
                               input logic br, input logic start, input logic mdu_use,
                               input logic done);
    stim_t s;
    s.memread = memread; s.wreg = wreg; s.rs = rs; s.rt = rt;
    s.use_rs = use_rs; s.use_rt = use_rt; s.br = br; s.start = start;
    s.mdu_use = mdu_use; s.done = done;
    return s;
  endfunction

  function automatic stim_t idle();
    return st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic apply(input stim_t s);
    MemReadEX = s.memread; writeregEX = s.wreg; insrs = s.rs; insrt = s.rt;
    UseRsID = s.use_rs; UseRtID = s.use_rt; BranchTakenEX = s.br;
    MduStartID = s.start; MduUseID = s.mdu_use; MduDone = s.done;
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_err = 1'b0;
    m_waited = 0;
    m_stalls = 0;
  endtask

  // Entered at posedge+1; drives, checks at the falling edge, advances model, returns at posedge+1.
  task automatic step(input stim_t s, input string tag);
    bit lu;
    bit mw;
    bit accept;
    logic [3:0] e;
    apply(s);
    #4;
    lu = s.memread && s.wreg != 0 &&
         ((s.use_rs && s.wreg == s.rs) || (s.use_rt && s.wreg == s.rt));
    mw = m_busy && s.mdu_use && !s.done;
    if (s.br) e = 4'b0011;
    else if (lu || mw || m_err) e = 4'b1110;
    else e = 4'b0000;
    check1({tag, ".pchold"}, PChold, e[3]);
    check1({tag, ".ifidhold"}, IFIDhold, e[2]);
    check1({tag, ".idexflush"}, IDEXflush, e[1]);
    check1({tag, ".ifidflush"}, IFIDflush, e[0]);
    check1({tag, ".busy"}, MduBusy, m_busy);
    check1({tag, ".err"}, MduErr, m_err);
    check16({tag, ".stallcnt"}, StallCnt, STALL_EN ? 16'(m_stalls) : 16'd0);
    accept = s.start && !s.br && !lu && !mw && !m_err;
    if (accept) begin
      m_busy = 1'b1;
      m_waited = 0;
    end else if (m_busy) begin
      if (s.done) begin
        m_busy = 1'b0;
      end else begin
        m_waited++;
        if (m_waited == TO) begin
          m_busy = 1'b0;
          m_err = 1'b1;
        end
      end
    end
    if (e[3] && m_stalls < 65535) m_stalls++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    apply(idle());
    rst = 1'b1;
    #2;
    check1({tag, ".rst_busy"}, MduBusy, 1'b0);
    check1({tag, ".rst_err"}, MduErr, 1'b0);
    check1({tag, ".rst_pchold"}, PChold, 1'b0);
    check16({tag, ".rst_stallcnt"}, StallCnt, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  vec_t tbl[13];

  initial begin
    stim_t s;

    tbl[0]  = '{st(1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0, 0), 5'b11100};
    tbl[1]  = '{st(0, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0, 0), 5'b00000};
    tbl[2]  = '{st(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0), 5'b00000};
    tbl[3]  = '{st(1, 5'd5, 5'd0, 5'd5, 0, 1, 1, 1, 0, 0), 5'b00110};
    tbl[4]  = '{idle(),                                    5'b00000};
    tbl[5]  = '{st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0), 5'b00000};
    tbl[6]  = '{st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0), 5'b11101};
    tbl[7]  = '{st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0), 5'b11101};
    tbl[8]  = '{st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0), 5'b11101};
    tbl[9]  = '{st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1), 5'b00001};
    tbl[10] = '{idle(),                                    5'b00000};
    tbl[11] = '{st(1, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0, 0, 0), 5'b11100};
    tbl[12] = '{st(1, 5'd7, 5'd7, 5'd7, 0, 0, 0, 0, 0, 0), 5'b00000};

    model_reset();
    do_reset("init");

    // Directed table: load-use, r0 exemption, branch priority, MDU wait/done.
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].s);
      #3;
      check16($sformatf("tbl%0d", i), 16'({PChold, IFIDhold, IDEXflush, IFIDflush, MduBusy}),
              16'(tbl[i].exp));
      #1;
      step(tbl[i].s, $sformatf("tbl%0d_model", i));
    end

    // Three separate load-use stalls, then asynchronous clear of the counter.
    do_reset("cnt");
    for (int i = 0; i < 3; i++) begin
      step(st(1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 0, 0, 0), "cnt_lu");
      step(idle(), "cnt_idle");
    end
    check16("cnt_three", StallCnt, STALL_EN ? 16'd3 : 16'd0);
    rst = 1'b1;
    #1;
    check16("cnt_async_clear", StallCnt, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // MDU timeout: eight wait cycles with no done, then trapped until reset.
    step(st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0), "to_start");
    for (int i = 0; i < TO - 1; i++) step(idle(), "to_wait");
    check1("to_not_yet", MduErr, 1'b0);
    check1("to_still_busy", MduBusy, 1'b1);
    step(idle(), "to_last");
    check1("to_err_set", MduErr, 1'b1);
    check1("to_busy_clear", MduBusy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(idle(), "to_stuck");
      check1("to_pchold_stuck", PChold, 1'b1);
    end
    apply(st(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0));
    #3;
    check1("to_branch_pchold", PChold, 1'b0);
    check1("to_branch_ifidflush", IFIDflush, 1'b1);
    #1;
    step(st(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0), "to_branch");
    do_reset("to_rst");
    check1("to_err_cleared", MduErr, 1'b0);

    // Reset in the middle of a wait leaves nothing pending.
    step(st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0), "mid_start");
    step(st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0), "mid_use");
    do_reset("mid_rst");
    apply(st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0));
    #3;
    check1("mid_no_stall", PChold, 1'b0);
    #1;
    step(st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0), "mid_after");

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0) do_reset("rand");
      s.memread = 1'($urandom_range(0, 1));
      s.wreg    = 5'($urandom_range(0, 3));
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.use_rs  = 1'($urandom_range(0, 1));
      s.use_rt  = 1'($urandom_range(0, 1));
      s.br      = ($urandom_range(0, 7) == 0);
      s.start   = ($urandom_range(0, 5) == 0);
      s.mdu_use = 1'($urandom_range(0, 1));
      s.done    = ($urandom_range(0, 5) == 0);
      step(s, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 Parameter MDU_TIMEOUT, default 40; max MDU_WAIT cycles before error, legal 2..63.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 MemReadEX  in  1  instruction in EX is a load.
REQ-005 writeregEX  in  5  destination register of EX instruction.
REQ-006 insrs, insrt  in  5 each  source register fields of ID instruction.
REQ-007 UseRsID, UseRtID  in  1 each  ID instruction actually reads rs / rt.
REQ-008 BranchTakenEX  in  1  taken branch/jump resolved in EX.
REQ-009 MduStartID  in  1  ID instruction issues a multi-cycle mult/div.
REQ-010 MduUseID  in  1  ID instruction reads HI/LO or issues an MDU op.
REQ-011 MduDone  in  1  multi-cycle unit result valid this cycle.
REQ-012 PChold, IFIDhold  out  1 each  freeze PC / IF-ID register.
REQ-013 IDEXflush, IFIDflush  out  1 each  insert bubble into ID-EX / clear IF-ID.
REQ-014 MduBusy  out  1  state is MDU_WAIT.
REQ-015 MduErr  out  1  sticky MDU timeout flag.
REQ-016 StallCnt  out  16  stall-cycle count (see Configuration).

Function
REQ-017 States: RUN, MDU_WAIT, MDU_ERR; 6-bit wait counter wcnt.
REQ-018 Hold/flush outputs combinational from state and inputs, same-cycle effect; state, wcnt, MduErr, StallCnt registered.
REQ-019 LU = MemReadEX and writeregEX!=0 and ((UseRsID and writeregEX==insrs) or (UseRtID and writeregEX==insrt)).
REQ-020 MW = state==MDU_WAIT and MduUseID and not MduDone.
REQ-021 Priority 1: BranchTakenEX -> IFIDflush=1, IDEXflush=1, PChold=0, IFIDhold=0; MDU start in ID is squashed (not accepted).
REQ-022 Priority 2: LU or MW -> PChold=1, IFIDhold=1, IDEXflush=1, IFIDflush=0.
REQ-023 Otherwise all four hold/flush outputs 0.
REQ-024 MDU start accepted when MduStartID and no branch and no LU and not MW and state!=MDU_ERR.
REQ-025 RUN: accepted start -> MDU_WAIT, wcnt<=0; MduDone ignored.
REQ-026 MDU_WAIT: wcnt increments each cycle; MduDone -> RUN, unless a start is accepted same cycle -> stay MDU_WAIT, wcnt<=0.
REQ-027 MDU_WAIT: wcnt==MDU_TIMEOUT-1 without MduDone -> MDU_ERR, MduErr<=1.
REQ-028 MDU_ERR: PChold=IFIDhold=1, IDEXflush=1 every cycle except branch cycles (REQ-021 still wins); exit only by reset.
REQ-029 Load-use stall lasts exactly one cycle per hazard (load advances to MEM); no state change from LU.

Reset
REQ-030 rst=1: state=RUN, wcnt=0, MduErr=0, StallCnt=0 immediately; combinational outputs follow RUN rules.
REQ-031 rst asserted mid-MDU_WAIT abandons the wait; no pending start is remembered.

Configuration
REQ-032 Macro HAZ_STALL_CNT_EN defined: StallCnt increments each cycle PChold==1, saturates at 0xFFFF.
REQ-033 Macro undefined: StallCnt constant 0, no counter logic.

Verification
REQ-034 MemReadEX=1, writeregEX=5, insrt=5, UseRtID=1 -> one cycle PChold=IFIDhold=IDEXflush=1, next cycle (MemReadEX=0) all 0.
REQ-035 writeregEX=0 matching insrs=0 with MemReadEX=1 -> no stall.
REQ-036 MduStartID=1 in RUN, then MduUseID=1 for 4 cycles, MduDone on 4th -> stall cycles 1-3, MduBusy 1 then 0 after done.
REQ-037 MDU_TIMEOUT=8, start, MduDone never -> MduErr=1 after 8 cycles in MDU_WAIT, PChold stuck 1 until rst.
REQ-038 BranchTakenEX=1 with LU=1 and MduStartID=1 same cycle -> IFIDflush=IDEXflush=1, PChold=0, state stays RUN.
REQ-039 With HAZ_STALL_CNT_EN: 3 load-use stalls -> StallCnt=3; rst -> StallCnt=0 asynchronously.
